mux_sweep_checker: RTL

MUX_SWEEP_CHECKER -- requirements
Module: mux_sweep_checker

---
 rtl/mux_sweep_checker_if.sv | 27 ++
 rtl/mux_sweep_checker.sv | 119 +++++++++++
 2 files changed

// File: rtl/mux_sweep_checker_if.sv
// Sweep-checker bus: start/abort control, mux stimulus a/b/c,
// observed z, and status/result outputs. slave = checker side.
interface mux_sweep_checker_if;
  logic       start;
  logic       abort;
  logic       z;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [7:0] fail_vec;

  modport master (
    output start, abort, z,
    input  a, b, c, busy, done, pass,
    input  err_count, fail_vec
  );

  modport slave (
    input  start, abort, z,
    output a, b, c, busy, done, pass,
    output err_count, fail_vec
  );
endinterface

// File: rtl/mux_sweep_checker.sv
// Exhaustive 8-vector sweep of a 2:1 mux stage (expect c ? b : a).
// Ports: clk, rst_n (async low), bus (slave): start/abort/z in; a/b/c, status out.
module mux_sweep_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_sweep_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_LOAD = 4'(SETTLE - 1);

  state_t     r_state;
  logic [2:0] r_vec;
  logic [3:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_c;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err;
  logic [7:0] r_fail;

  logic       w_exp;
  logic       w_miss;
  logic [3:0] w_err_inc;

  // Expectation uses the vector actually driven onto the mux.
  assign w_exp     = r_c ? r_b : r_a;
  assign w_miss    = bus.z != w_exp;
  assign w_err_inc = (r_err == 4'hF) ? r_err : r_err + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_c     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fail  <= '0;
    end else if (bus.abort) begin
      // Abort beats start everywhere; partial results are kept.
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_c     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state <= S_SETTLE;
            r_vec   <= '0;
            r_cnt   <= LP_LOAD;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_c     <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
          end
        end
        S_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CHECK: begin
          if (w_miss) begin
            r_err         <= w_err_inc;
            r_fail[r_vec] <= 1'b1;
          end
          if (r_vec == 3'd7) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= !w_miss && (r_err == 4'd0);
          end else begin
            r_state       <= S_SETTLE;
            r_vec         <= r_vec + 3'd1;
            {r_a,r_b,r_c} <= r_vec + 3'd1;
            r_cnt         <= LP_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.c         = r_c;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.fail_vec  = r_fail;

endmodule
